// File: rtl/contador_minutos.sv
// Minutes stage of the digital clock: seconds prescaler, BCD minutes,
// hour carry and a push-button set mode.
module contador_minutos #(
    parameter int SEG_POR_MIN = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_seg,
    input  logic       modo_ajuste,
    input  logic       btn_inc,
    output logic [2:0] decenas,
    output logic [3:0] unidades,
    output logic [5:0] segundos,
    output logic       acarreo_hora
);

    localparam logic [5:0] SEG_MAX = 6'(SEG_POR_MIN - 1);

    typedef enum logic {
        CORRIENDO = 1'b0,
        AJUSTE    = 1'b1
    } estado_t;

    estado_t    estado_q;
    logic [2:0] decenas_q, decenas_d;
    logic [3:0] unidades_q, unidades_d;
    logic [5:0] segundos_q;
    logic       acarreo_q;
    logic       sync1_q, sync2_q, prev_q;
    logic       vuelta;
    logic       flanco;

    // Next BCD minute; out-of-range digits collapse to 0.
    always_comb begin
        unidades_d = unidades_q + 4'd1;
        decenas_d  = decenas_q;
        if (unidades_q >= 4'd9) begin
            unidades_d = 4'd0;
            decenas_d  = (decenas_q >= 3'd5) ? 3'd0 : decenas_q + 3'd1;
        end
        if (decenas_q > 3'd5) begin
            decenas_d = 3'd0;
        end
    end

    assign vuelta = (decenas_q == 3'd5) && (unidades_q == 4'd9);
    assign flanco = sync2_q && !prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= CORRIENDO;
            decenas_q  <= 3'd0;
            unidades_q <= 4'd0;
            segundos_q <= 6'd0;
            acarreo_q  <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_inc;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            acarreo_q <= 1'b0;
            unique case (estado_q)
                CORRIENDO: begin
                    if (tick_seg) begin
                        if (segundos_q >= SEG_MAX) begin
                            segundos_q <= 6'd0;
                            decenas_q  <= decenas_d;
                            unidades_q <= unidades_d;
                            acarreo_q  <= vuelta;
                        end else begin
                            segundos_q <= segundos_q + 6'd1;
                        end
                    end
                    // Entering set mode zeroes the seconds on this edge.
                    if (modo_ajuste) begin
                        estado_q   <= AJUSTE;
                        segundos_q <= 6'd0;
                    end
                end
                AJUSTE: begin
                    segundos_q <= 6'd0;
                    if (flanco) begin
                        decenas_q  <= decenas_d;
                        unidades_q <= unidades_d;
                    end
                    if (!modo_ajuste) begin
                        estado_q <= CORRIENDO;
                    end
                end
                default: estado_q <= CORRIENDO;
            endcase
        end
    end

    assign decenas      = decenas_q;
    assign unidades     = unidades_q;
    assign segundos     = segundos_q;
    assign acarreo_hora = acarreo_q;

endmodule

// File: tb/tb_contador_minutos.sv
// Directed bench for contador_minutos with a 4-tick minute.
module tb_contador_minutos;

    logic       clk;
    logic       rst_n;
    logic       tick_seg;
    logic       modo_ajuste;
    logic       btn_inc;
    logic [2:0] decenas;
    logic [3:0] unidades;
    logic [5:0] segundos;
    logic       acarreo_hora;

    int n_pass  = 0;
    int n_total = 0;
    int exp_min = 0;

    contador_minutos #(.SEG_POR_MIN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_seg     (tick_seg),
        .modo_ajuste  (modo_ajuste),
        .btn_inc      (btn_inc),
        .decenas      (decenas),
        .unidades     (unidades),
        .segundos     (segundos),
        .acarreo_hora (acarreo_hora)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_min(input string tag, input int m);
        chk({tag, "_dec"}, int'(decenas), m / 10);
        chk({tag, "_uni"}, int'(unidades), m % 10);
    endtask

    // Inputs change at negedge; outputs sampled 1ns after posedge.
    task automatic step(input logic t, input logic m, input logic b);
        @(negedge clk);
        tick_seg    = t;
        modo_ajuste = m;
        btn_inc     = b;
        @(posedge clk);
        #1;
    endtask

    // One-cycle button press in set mode; minutes move on the 3rd edge.
    task automatic pulse(input logic t, input string tag);
        step(t, 1'b1, 1'b1);
        step(t, 1'b1, 1'b0);
        chk_min({tag, "_pre"}, exp_min);
        step(t, 1'b1, 1'b0);
        exp_min = (exp_min + 1) % 60;
        chk_min(tag, exp_min);
        chk({tag, "_carry"}, int'(acarreo_hora), 0);
        chk({tag, "_seg"}, int'(segundos), 0);
        step(t, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        tick_seg    = 1'b0;
        modo_ajuste = 1'b0;
        btn_inc     = 1'b0;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk_min("rst", 0);
        chk("rst_seg", int'(segundos), 0);
        chk("rst_carry", int'(acarreo_hora), 0);
        rst_n = 1'b1;
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk_min("idle", 0);
        chk("idle_seg", int'(segundos), 0);
        chk("idle_carry", int'(acarreo_hora), 0);

        // 2: four ticks make one minute
        step(1'b1, 1'b0, 1'b0);
        chk("t1_seg", int'(segundos), 1);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_seg", int'(segundos), 2);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_seg", int'(segundos), 3);
        chk("t3_uni", int'(unidades), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_seg", int'(segundos), 0);
        chk("t4_uni", int'(unidades), 1);
        chk("t4_carry", int'(acarreo_hora), 0);
        exp_min = 1;

        // 3: reach 09:3 via set mode, then tick into 10
        step(1'b0, 1'b1, 1'b0);
        repeat (8) pulse(1'b0, "set09");
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk_min("m09", 9);
        chk("m09_seg", int'(segundos), 3);
        step(1'b1, 1'b0, 1'b0);
        chk_min("m10", 10);
        chk("m10_seg", int'(segundos), 0);
        chk("m10_carry", int'(acarreo_hora), 0);
        exp_min = 10;

        // 4: reach 59:3, tick wraps with one-cycle carry
        step(1'b0, 1'b1, 1'b0);
        repeat (49) pulse(1'b0, "set59");
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk_min("m59", 59);
        chk("m59_seg", int'(segundos), 3);
        chk("m59_carry", int'(acarreo_hora), 0);
        step(1'b1, 1'b0, 1'b0);
        chk_min("m00", 0);
        chk("m00_seg", int'(segundos), 0);
        chk("m00_carry", int'(acarreo_hora), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("m00_carry_off", int'(acarreo_hora), 0);
        exp_min = 0;

        // 5: set mode with ticks every cycle
        step(1'b1, 1'b1, 1'b0);
        chk("aj_entry_seg", int'(segundos), 0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("aj_hold_seg", int'(segundos), 0);
        chk_min("aj_hold", 0);
        repeat (58) pulse(1'b1, "set58");
        chk_min("at58", 58);
        pulse(1'b1, "p59");
        pulse(1'b1, "p00");
        pulse(1'b1, "p01");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (i == 2) chk_min("hold_step", 2);
            chk("hold_carry", int'(acarreo_hora), 0);
        end
        repeat (4) step(1'b1, 1'b1, 1'b0);
        chk_min("hold_once", 2);
        chk("hold_seg", int'(segundos), 0);

        // 6: async reset between edges
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("pre_rst_seg", int'(segundos), 2);
        chk_min("pre_rst", 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_min("async", 0);
        chk("async_seg", int'(segundos), 0);
        chk("async_carry", int'(acarreo_hora), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
